mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one shared memory port.
// Each requester owns a single pending slot; ties alternate via last_grant, with a timeout abort.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  output logic        i_busy,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_start,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_busy,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned CLOG = $clog2(TIMEOUT + 1);
  localparam int unsigned CW   = (CLOG > 8) ? CLOG : 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [31:0]   i_addr_q;
  logic [31:0]   d_addr_q;
  logic [31:0]   d_wdata_q;
  logic          d_we_q;
  logic          last_d;
  logic          gnt_d;
  logic          pick_d;
  logic          timeout;
  logic [CW-1:0] cnt;

  // i_busy/d_busy double as the slot-valid flags; fetch wins a tie unless it was served last.
  assign pick_d  = d_busy && (!i_busy || !last_d);
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_we_q    <= 1'b0;
      last_d    <= 1'b1;
      gnt_d     <= 1'b0;
      cnt       <= '0;
      i_busy    <= 1'b0;
      i_done    <= 1'b0;
      i_rdata   <= '0;
      d_busy    <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_busy || d_busy) begin
            gnt_d     <= pick_d;
            mem_req   <= 1'b1;
            mem_we    <= pick_d ? d_we_q : 1'b0;
            mem_addr  <= pick_d ? d_addr_q : i_addr_q;
            mem_wdata <= pick_d ? d_wdata_q : '0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // ack takes priority over a timeout landing in the same cycle
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
            err     <= !mem_ack;
            last_d  <= gnt_d;
            state   <= RESP;
            if (gnt_d) begin
              d_busy <= 1'b0;
              d_done <= 1'b1;
              if (!d_we_q) d_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              i_busy  <= 1'b0;
              i_done  <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase

      // a slot is only cleared while busy, so accepting only while idle never collides
      if (i_start && !i_busy) begin
        i_busy   <= 1'b1;
        i_addr_q <= i_addr;
      end
      if (d_start && !d_busy) begin
        d_busy    <= 1'b1;
        d_we_q    <= d_we;
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
      end
    end
  end

endmodule
